// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder: two half-adder stages plus a carry OR, gate primitives only.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    wire s1;
    wire c1;
    wire c2;

    xor x_ha1 (s1, a, b);
    and a_ha1 (c1, a, b);
    xor x_ha2 (s, s1, ci);
    and a_ha2 (c2, s1, ci);
    or  o_co  (co, c1, c2);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, WIDTH cycles per operation.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; out_valid holds until out_ready.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             busy,
    output state_t           dbg_state_o
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             s;
    logic             c;
    logic [WIDTH-1:0] res_d;

    full_adder_cell u_cell (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (s),
        .co (c)
    );

    // a_sh doubles as the result shifter: each consumed LSB frees an MSB slot for the new sum bit.
    if (WIDTH == 1) begin : g_w1
        assign res_d = s;
    end else begin : g_wn
        assign res_d = {s, a_sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= res_d;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= c;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= c;
                        ovf_q   <= carry_q ^ c;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign out_valid   = (state_q == DONE);
    assign sum_out     = sum_q;
    assign cout_out    = cout_q;
    assign ovf_out     = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8, plus a WIDTH=1 instance.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, cin, out_valid, out_ready, cout_out, ovf_out, busy;
    logic [7:0] a_in, b_in, sum_out;
    state_t     dbg_state;

    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout_out1, ovf_out1, busy1;
    logic [0:0] a_in1, b_in1, sum_out1;
    state_t     dbg_state1;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum_out(sum_out), .cout_out(cout_out),
        .ovf_out(ovf_out), .busy(busy), .dbg_state_o(dbg_state)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_in(a_in1), .b_in(b_in1), .cin(cin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum_out(sum_out1), .cout_out(cout_out1),
        .ovf_out(ovf_out1), .busy(busy1), .dbg_state_o(dbg_state1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        a_in     = a;
        b_in     = b;
        cin      = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        start_op(a, b, c);
        wait_result(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd8);
        check({tag, "_sum"}, 32'(sum_out), 32'(es));
        check({tag, "_cout"}, 32'(cout_out), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf_out), 32'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    task automatic run_op1(input string tag, input logic a, input logic b, input logic c,
                           input logic es, input logic ec, input logic eo);
        int cyc = 0;
        a_in1     = a;
        b_in1     = b;
        cin1      = c;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        while (!out_valid1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd1);
        check({tag, "_sco"}, {29'd0, sum_out1, cout_out1, ovf_out1}, {29'd0, es, ec, eo});
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check({tag, "_idle"}, 32'(in_ready1), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         stray;
        logic [8:0] full;
        logic [7:0] ra, rb, rs;
        logic       rc, ro;
        logic [9:0] got;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a_in1 = '0; b_in1 = '0; cin1 = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flags", {29'd0, out_valid, busy, cout_out | ovf_out}, 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_w1", {28'd0, in_ready1, out_valid1, busy1, sum_out1}, 32'b1000);

        run_op("sovf",  8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        run_op("wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("allff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("novf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("cinonly", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        // Backpressure: hold the result for 5 cycles and poke in_valid meanwhile.
        start_op(8'h7F, 8'h01, 1'b0);
        wait_result(cyc);
        check("bp_latency", 32'(cyc), 32'd8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a_in = 8'h01; b_in = 8'h01; cin = 1'b1; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("bp_hold", {21'd0, out_valid, in_ready, sum_out, cout_out, ovf_out},
                  {21'd0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'b100);
        stray = 0;
        repeat (12) begin
            tick();
            if (out_valid || busy) stray++;
        end
        check("bp_no_extra", 32'(stray), 32'd0);

        // Reset during the third RUN cycle.
        start_op(8'hAA, 8'h55, 1'b1);
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_abort", {29'd0, in_ready, out_valid, busy}, 32'b100);
        stray = 0;
        repeat (12) begin
            tick();
            if (out_valid) stray++;
        end
        check("mid_no_result", 32'(stray), 32'd0);
        run_op("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // WIDTH=1 instance.
        run_op1("w1_111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op1("w1_110", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op1("w1_100", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized back-to-back operations with random output stalls.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            rs = full[7:0];
            ro = (ra[7] == rb[7]) && (rs[7] != ra[7]);
            exp_q.push_back({rs, full[8], ro});
            start_op(ra, rb, rc);
            wait_result(cyc);
            if (cyc >= 100) check("rand_timeout", 32'(cyc), 32'd8);
            repeat ($urandom_range(0, 3)) tick();
            got = {sum_out, cout_out, ovf_out};
            check("rand_result", {21'd0, out_valid, got}, {21'd0, 1'b1, exp_q.pop_front()});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Adds one bit per clock, LSB first, through a single full-adder cell. The cell is two half-adder stages plus a carry OR.
- Returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits directly downstream of the gate-level adder cells. It is the sequential consumer of their sum/carry outputs, trading WIDTH cycles of latency for one adder cell.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept an operand set
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- sum_out  output  WIDTH  A+B+cin, modulo 2^WIDTH
- cout_out  output  1  unsigned carry-out
- ovf_out  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
- busy  output  1  high in RUN

Behaviour:
- Clock and reset: single clock domain clk. rst is synchronous and active-high.
- Reset response: on rst, state=IDLE, counter=0, carry register=0, shift registers=0. All outputs go low except in_ready, which is 1 the cycle after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture a_in, b_in into shift registers a_sh, b_sh and cin into carry_q. Clear cnt. Go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the cell computes s,c from a_sh[0], b_sh[0], carry_q.
  - At the clock edge, a_sh and b_sh shift right by 1. s shifts into the MSB of res_sh (right shift), carry_q<=c, cnt<=cnt+1.
  - On the cycle where cnt==WIDTH-1, also latch ovf_q = carry_q XOR c, using carry_q before update. Then go to DONE.
- DONE:
  - out_valid=1, sum_out=res_sh, cout_out=carry_q, ovf_out=ovf_q. All outputs are held stable.
  - On out_ready: go to IDLE.
- Latency: the accept edge is edge 0. out_valid is high after edge WIDTH, so exactly WIDTH cycles in RUN. Throughput is one operation per WIDTH+2 cycles at minimum.
- Output timing:
  - sum_out, cout_out and ovf_out are registered.
  - sum_out, cout_out and ovf_out are 0 outside DONE.
  - out_valid never drops without out_ready.
- Ignored inputs: in_valid outside IDLE is ignored. a_in, b_in and cin are sampled only at the accept edge.
- Width rules:
  - cnt is max(1,$clog2(WIDTH)) bits and never exceeds WIDTH-1.
  - WIDTH=1: a single RUN cycle, and ovf_out = cin XOR cout.
- Reset mid-operation: rst in RUN or DONE aborts with no result produced. The next cycle is IDLE with in_ready=1.
- Simultaneous rst with in_valid or out_ready: rst wins.
- No result is ever emitted twice.

Decomposition:
- Package serial_adder_pkg:
  - state_t enum {IDLE, RUN, DONE}, 2 bits.
  - Function cnt_w(WIDTH) returning max(1,$clog2(WIDTH)).
- Sub-module full_adder_cell:
  - Ports a, b, ci, s, co.
  - Structural: half-adder stage on a,b; second half-adder stage on that sum and ci; co = OR of the two carries.
  - Built from gate primitives only, with no clock.
  - Instantiated once inside serial_adder.

Test Plan (WIDTH=8):
- Signed overflow: a=0x5A, b=0x33, cin=0 -> out_valid exactly 8 cycles after accept; sum=0x8D, cout=0, ovf=1.
- Unsigned wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Negative overflow: a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stay stable; in_ready=0; a new in_valid pulse is ignored. Assert out_ready -> IDLE and in_ready=1 next cycle.
- Reset mid-operation: assert rst on the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, busy=0; no result ever appears. A following add of 0x12+0x34 gives 0x46.
- Random and WIDTH=1 checks:
  - 1000 random back-to-back operations with random out_ready stalls match a reference model (A+B+cin, signed overflow).
  - Separate WIDTH=1 build: 1+1+1 -> sum=1, cout=1, ovf=0.
